leaf_out_arbiter: RTL and testbench
===================================

Name: leaf_out_arbiter

Overview:
- Shares the single leaf-to-BFT output link among NUM_OUT_PORTS user output streams. Each stream is a 32-bit vld/ack stream.
- Round-robin arbitration, gated by per-port destination credits.
- Packetizes each granted word as {valid, dest_leaf, dest_port, seq_addr, payload} using a per-port destination table.
- Sits between the user kernel outputs and the BFT egress path, inside the leaf shell in the clk_400 domain.

Parameters:
- PACKET_BITS, 49, output packet width; must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS.
- PAYLOAD_BITS, 32, user word width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width; also the width of the local port index.
- NUM_ADDR_BITS, 7, per-port sequence/address field width.
- NUM_OUT_PORTS, 5, number of user output streams (1..2^NUM_PORT_BITS).
- CREDIT_INIT, 64, credits per port after reset (matches FREESPACE_UPDATE_SIZE).
- CREDIT_BITS, 8, credit counter width.

Ports:
- clk  in  1  leaf clock.
- reset  in  1  asynchronous, active-high reset.
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user words; port i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_user2interface  in  NUM_OUT_PORTS  per-port word valid.
- ack_interface2user  out  NUM_OUT_PORTS  per-port accept. A transfer occurs when vld and ack are both high in a cycle.
- cfg_wr  in  1  destination table write strobe.
- cfg_port  in  NUM_PORT_BITS  local port to configure.
- cfg_dest_leaf  in  NUM_LEAF_BITS  destination leaf.
- cfg_dest_port  in  NUM_PORT_BITS  destination port.
- credit_upd_vld  in  1  freespace credit return strobe.
- credit_upd_port  in  NUM_PORT_BITS  port receiving credits.
- credit_upd_amt  in  CREDIT_BITS  credits returned.
- out_ready  in  1  egress can accept the held packet this cycle.
- resend  in  1  freeze: no grants and no output advance while high.
- dout_leaf_interface2bft  out  PACKET_BITS  registered packet; MSB is the valid bit.

Behaviour:
- Reset (async):
  - dout = 0, all acks = 0.
  - All credits = CREDIT_INIT; all configured bits = 0; dest table = 0; seq counters = 0.
  - rr_ptr = NUM_OUT_PORTS-1, so port 0 has first priority.
  - FSM = EMPTY.
  - Reset asserted mid-operation drops any held packet; no ack follows reset release until a new grant.
- Packet format:
  - [48] = 1.
  - [47:43] = dest_leaf.
  - [42:39] = dest_port.
  - [38:32] = seq[i].
  - [31:0] = payload.
- FSM states:
  - EMPTY: dout[MSB] = 0.
  - FULL: dout holds a valid packet until it is accepted.
- can_load = (EMPTY | out_ready) & ~resend.
- Eligibility: port i is eligible iff vld[i] & configured[i] & credit[i] != 0.
- Grant:
  - When can_load is high, grant the first eligible port scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_OUT_PORTS.
  - ack[grant] = 1 combinationally in the same cycle. At most one ack per cycle; ack never asserts while vld is low.
- On grant, at the next edge:
  - dout <= packet; FSM -> FULL.
  - rr_ptr <= grant.
  - seq[grant] += 1, wrapping 2^NUM_ADDR_BITS-1 -> 0.
  - credit[grant] -= 1.
- Latency: 1 cycle from ack to packet on dout.
- No grant while can_load is high:
  - If FULL and out_ready, go to EMPTY and clear dout to 0.
  - Otherwise dout holds.
- FULL & ~out_ready, or resend high: dout held unchanged and no acks. Back-to-back throughput is 1 word/cycle while out_ready stays high.
- Credit update: credit[p] += amt, saturating at 2^CREDIT_BITS-1. Updates with p >= NUM_OUT_PORTS are ignored.
- Simultaneous grant and update on the same port: new credit = credit - 1 + amt, saturating.
- Credit 0: port is ineligible and its vld is held off (no ack) until credits return.
- Config write:
  - Sets dest_leaf/dest_port and configured[cfg_port] = 1.
  - Credits and seq are unchanged.
  - Writes with cfg_port >= NUM_OUT_PORTS are ignored.
  - A write in the same cycle as a grant on that port takes effect for the next grant; the current packet uses the old table entry.
- rr_ptr changes only on grant.

Test Plan:
- Reset, configure port 0 -> leaf 3, port 2; drive vld[0] = 1 with data 0xDEADBEEF, out_ready = 1 -> ack[0] in cycle N; dout in N+1 = {1, 5'd3, 4'd2, 7'd0, 0xDEADBEEF}; next word has seq 1.
- Configure all 5 ports; hold all vld high and out_ready = 1 -> grants in order 0,1,2,3,4,0; exactly one ack per cycle; each port advances seq independently.
- Port 1 only; send 64 words with no credit return -> 64 acks, then ack[1] stays 0. Return credit_upd_amt = 2 -> exactly 2 more transfers. Credit at 255 plus update of 10 -> saturates at 255.
- Port 2 streaming; hold out_ready = 0 for 3 cycles, then pulse resend for 2 cycles -> dout stable and no acks throughout; resumes with no lost or duplicated seq values.
- Send 130 words on port 0 with credits replenished -> seq field reads 127 then 0, 1; unconfigured port 4 with vld high never acked; assert reset while FULL -> dout = 0 immediately, no ack in the first cycle after release without a valid request.

Source files
------------

// File: rtl/leaf_out_arbiter.sv
// Round-robin, credit-gated arbiter that packetizes user output streams onto
// the single leaf-to-BFT link, holding each packet until egress accepts it.
module leaf_out_arbiter #(
    parameter int unsigned PACKET_BITS   = 49,
    parameter int unsigned PAYLOAD_BITS  = 32,
    parameter int unsigned NUM_LEAF_BITS = 5,
    parameter int unsigned NUM_PORT_BITS = 4,
    parameter int unsigned NUM_ADDR_BITS = 7,
    parameter int unsigned NUM_OUT_PORTS = 5,
    parameter int unsigned CREDIT_INIT   = 64,
    parameter int unsigned CREDIT_BITS   = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    cfg_wr,
    input  logic [NUM_PORT_BITS-1:0]                cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port,
    input  logic                                    credit_upd_vld,
    input  logic [NUM_PORT_BITS-1:0]                credit_upd_port,
    input  logic [CREDIT_BITS-1:0]                  credit_upd_amt,
    input  logic                                    out_ready,
    input  logic                                    resend,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft
);

    localparam int unsigned N  = NUM_OUT_PORTS;
    localparam int unsigned CW = CREDIT_BITS + 1;
    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = '1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [PACKET_BITS-1:0]   r_dout;
    logic [PACKET_BITS-1:0]   w_dout_nxt;
    logic [PACKET_BITS-1:0]   w_packet;
    logic [NUM_PORT_BITS-1:0] r_rr_ptr;
    logic [CREDIT_BITS-1:0]   r_credit     [N];
    logic [CREDIT_BITS-1:0]   w_credit_nxt [N];
    logic [NUM_ADDR_BITS-1:0] r_seq        [N];
    logic [NUM_LEAF_BITS-1:0] r_dest_leaf  [N];
    logic [NUM_PORT_BITS-1:0] r_dest_port  [N];
    logic [N-1:0]             r_cfgd;
    logic [N-1:0]             w_elig;
    logic [N-1:0]             w_ack;
    logic                     w_can_load;
    logic                     w_grant_vld;
    logic [NUM_PORT_BITS-1:0] w_grant_idx;

    assign w_can_load = ((r_state == ST_EMPTY) || out_ready) && !resend;

    always_comb begin
        w_elig = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_elig[i] = vld_user2interface[i] && r_cfgd[i] && (r_credit[i] != '0);
        end
    end

    // Rank each eligible port by its distance past rr_ptr; the nearest wins.
    always_comb begin
        int unsigned v_ptr;
        int unsigned v_pos;
        int unsigned v_best;
        v_ptr       = 32'(r_rr_ptr);
        v_pos       = 0;
        v_best      = N + 1;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_ack       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            v_pos = (i > v_ptr) ? (i - v_ptr) : (i + N - v_ptr);
            if (w_can_load && w_elig[i] && (v_pos < v_best)) begin
                v_best      = v_pos;
                w_grant_vld = 1'b1;
                w_grant_idx = NUM_PORT_BITS'(i);
                w_ack       = '0;
                w_ack[i]    = 1'b1;
            end
        end
    end

    always_comb begin
        w_packet = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_ack[i]) begin
                w_packet = PACKET_BITS'({1'b1, r_dest_leaf[i], r_dest_port[i], r_seq[i],
                                         din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]});
            end
        end
    end

    // Grant consumes one credit; a same-cycle return is added on top, saturating.
    always_comb begin
        logic [CW-1:0] v_sum;
        logic [CW-1:0] v_add;
        v_sum = '0;
        v_add = '0;
        for (int unsigned i = 0; i < N; i++) begin
            v_add = (credit_upd_vld && (credit_upd_port == NUM_PORT_BITS'(i)))
                    ? CW'(credit_upd_amt) : '0;
            v_sum = CW'(r_credit[i]) + v_add - CW'(w_ack[i]);
            w_credit_nxt[i] = (v_sum > CW'(CREDIT_MAX)) ? CREDIT_MAX : CREDIT_BITS'(v_sum);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dout_nxt  = r_dout;
        if (w_grant_vld) begin
            w_state_nxt = ST_FULL;
            w_dout_nxt  = w_packet;
        end else if (w_can_load && (r_state == ST_FULL) && out_ready) begin
            w_state_nxt = ST_EMPTY;
            w_dout_nxt  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= NUM_PORT_BITS'(N - 1);
            r_cfgd   <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                r_credit[i]    <= CREDIT_BITS'(CREDIT_INIT);
                r_seq[i]       <= '0;
                r_dest_leaf[i] <= '0;
                r_dest_port[i] <= '0;
            end
        end else begin
            if (w_grant_vld) begin
                r_rr_ptr <= w_grant_idx;
            end
            for (int unsigned i = 0; i < N; i++) begin
                r_credit[i] <= w_credit_nxt[i];
                if (w_ack[i]) begin
                    r_seq[i] <= r_seq[i] + NUM_ADDR_BITS'(1);
                end
                // Table update lands after this cycle's packet was built from the old entry.
                if (cfg_wr && (cfg_port == NUM_PORT_BITS'(i))) begin
                    r_dest_leaf[i] <= cfg_dest_leaf;
                    r_dest_port[i] <= cfg_dest_port;
                    r_cfgd[i]      <= 1'b1;
                end
            end
        end
    end

    assign ack_interface2user      = w_ack;
    assign dout_leaf_interface2bft = r_dout;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Scoreboard bench for leaf_out_arbiter: a behavioural model predicts acks and
// queues expected packets, which are popped when they should appear on dout.
module tb_leaf_out_arbiter;

    localparam int N  = 5;
    localparam int PB = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [N*PB-1:0]  din;
    logic [N-1:0]     vld;
    logic [N-1:0]     ack;
    logic             cfg_wr;
    logic [3:0]       cfg_port;
    logic [4:0]       cfg_dest_leaf;
    logic [3:0]       cfg_dest_port;
    logic             credit_upd_vld;
    logic [3:0]       credit_upd_port;
    logic [7:0]       credit_upd_amt;
    logic             out_ready;
    logic             resend;
    logic [48:0]      dout;

    leaf_out_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .cfg_wr                  (cfg_wr),
        .cfg_port                (cfg_port),
        .cfg_dest_leaf           (cfg_dest_leaf),
        .cfg_dest_port           (cfg_dest_port),
        .credit_upd_vld          (credit_upd_vld),
        .credit_upd_port         (credit_upd_port),
        .credit_upd_amt          (credit_upd_amt),
        .out_ready               (out_ready),
        .resend                  (resend),
        .dout_leaf_interface2bft (dout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          m_credit [N];
    logic [6:0]  m_seq    [N];
    logic [4:0]  m_leaf   [N];
    logic [3:0]  m_dport  [N];
    bit          m_cfgd   [N];
    int          m_xfer   [N];
    int          m_rr;
    bit          m_full;
    bit          m_new;
    logic [48:0] m_hold;
    logic [48:0] sb_q [$];

    initial begin
        for (int i = 0; i < N; i++) m_xfer[i] = 0;
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_credit[i] = 64;
            m_seq[i]    = '0;
            m_leaf[i]   = '0;
            m_dport[i]  = '0;
            m_cfgd[i]   = 1'b0;
        end
        m_rr   = N - 1;
        m_full = 1'b0;
        m_new  = 1'b0;
        m_hold = '0;
        sb_q.delete();
    endtask

    // Inputs are stable at the falling edge: check outputs, then advance the model.
    always @(negedge clk) begin
        int          g;
        int          idx;
        bit          can;
        logic [4:0]  exp_ack;
        logic [48:0] pkt;
        if (reset) begin
            model_reset();
            check_eq("rst_dout", 64'(dout), 64'd0);
            check_eq("rst_ack", 64'(ack), 64'd0);
        end else begin
            if (m_full) begin
                if (m_new) begin
                    check_eq("sb_depth", 64'(sb_q.size()), 64'd1);
                    if (sb_q.size() > 0) m_hold = sb_q.pop_front();
                end
                check_eq("dout", 64'(dout), 64'(m_hold));
            end else begin
                check_eq("dout_idle", 64'(dout), 64'd0);
            end
            can = (!m_full || out_ready) && !resend;
            g   = -1;
            if (can) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_rr + k) % N;
                    if (g < 0 && vld[idx] && m_cfgd[idx] && m_credit[idx] > 0) g = idx;
                end
            end
            exp_ack = (g >= 0) ? (5'(1) << g) : 5'd0;
            check_eq("ack", 64'(ack), 64'(exp_ack));
            m_new = 1'b0;
            if (g >= 0) begin
                pkt = {1'b1, m_leaf[g], m_dport[g], m_seq[g], din[g*PB +: PB]};
                sb_q.push_back(pkt);
                m_seq[g]    = m_seq[g] + 7'd1;
                m_rr        = g;
                m_full      = 1'b1;
                m_new       = 1'b1;
                m_credit[g] = m_credit[g] - 1;
                m_xfer[g]   = m_xfer[g] + 1;
            end else if (can && m_full) begin
                m_full = 1'b0;
            end
            if (credit_upd_vld && int'(credit_upd_port) < N) begin
                m_credit[int'(credit_upd_port)] += int'(credit_upd_amt);
                if (m_credit[int'(credit_upd_port)] > 255) m_credit[int'(credit_upd_port)] = 255;
            end
            if (cfg_wr && int'(cfg_port) < N) begin
                m_leaf[int'(cfg_port)]  = cfg_dest_leaf;
                m_dport[int'(cfg_port)] = cfg_dest_port;
                m_cfgd[int'(cfg_port)]  = 1'b1;
            end
        end
    end

    bit rnd_din = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_din) begin
            for (int i = 0; i < N; i++) din[i*PB +: PB] = $urandom;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic cfg_write(input int p, input int leaf, input int dport);
        cfg_wr        = 1'b1;
        cfg_port      = 4'(p);
        cfg_dest_leaf = 5'(leaf);
        cfg_dest_port = 4'(dport);
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic credit_ret(input int p, input int amt);
        credit_upd_vld  = 1'b1;
        credit_upd_port = 4'(p);
        credit_upd_amt  = 8'(amt);
        tick();
        credit_upd_vld = 1'b0;
    endtask

    initial begin
        int base0;
        int base4;
        reset = 1'b1; din = '0; vld = '0; cfg_wr = 1'b0; cfg_port = '0;
        cfg_dest_leaf = '0; cfg_dest_port = '0; credit_upd_vld = 1'b0;
        credit_upd_port = '0; credit_upd_amt = '0; out_ready = 1'b1; resend = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Single-port packet format and sequence start
        rnd_din = 1'b0;
        cfg_write(0, 3, 2);
        din[31:0] = 32'hDEADBEEF;
        vld[0]    = 1'b1;
        @(negedge clk);
        check_eq("t1_ack", 64'(ack), 64'd1);
        tick();
        check_eq("t1_pkt", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
        tick();
        check_eq("t1_seq1", 64'(dout[38:32]), 64'd1);
        vld = '0;
        rnd_din = 1'b1;
        repeat (2) tick();

        // All ports requesting: strict rotation from port 0
        do_reset();
        for (int i = 0; i < N; i++) cfg_write(i, i + 1, i);
        vld = '1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("t2_rr_ack", 64'(ack), 64'(5'(1) << (k % N)));
            tick();
        end
        vld = '0;
        repeat (2) tick();

        // Credit exhaustion, partial return, saturation
        do_reset();
        cfg_write(1, 7, 1);
        base0 = m_xfer[1];
        vld[1] = 1'b1;
        repeat (70) tick();
        check_eq("t3_exhaust", 64'(m_xfer[1] - base0), 64'd64);
        credit_ret(1, 2);
        repeat (5) tick();
        check_eq("t3_return2", 64'(m_xfer[1] - base0), 64'd66);
        vld[1] = 1'b0;
        credit_ret(1, 255);
        credit_ret(1, 10);
        vld[1] = 1'b1;
        repeat (260) tick();
        check_eq("t3_saturate", 64'(m_xfer[1] - base0), 64'd321);
        vld = '0;
        repeat (2) tick();

        // Back-pressure then resend freeze
        do_reset();
        cfg_write(2, 9, 5);
        vld[2] = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("t4_stall_ack", 64'(ack), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        resend    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("t4_resend_ack", 64'(ack), 64'd0);
            tick();
        end
        resend = 1'b0;
        repeat (4) tick();
        vld = '0;
        repeat (2) tick();

        // Sequence wrap, unconfigured port, reset while FULL
        do_reset();
        cfg_write(0, 1, 1);
        credit_ret(0, 200);
        base0 = m_xfer[0];
        base4 = m_xfer[4];
        vld   = 5'b10001;
        repeat (135) tick();
        check_eq("t5_port0_xfers", 64'(m_xfer[0] - base0), 64'd135);
        check_eq("t5_port4_never", 64'(m_xfer[4] - base4), 64'd0);
        reset = 1'b1;
        #1;
        check_eq("t5_async_dout", 64'(dout), 64'd0);
        check_eq("t5_async_ack", 64'(ack), 64'd0);
        vld = '0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("t5_post_ack", 64'(ack), 64'd0);
        check_eq("t5_post_dout", 64'(dout), 64'd0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
